// File: rtl/hilo_acc_unit.sv
// ============================================================================
// hilo_acc_unit
//
// HI/LO register pair with a multi-cycle multiply-accumulate datapath. The
// 2*DATA_W accumulator is held as {HI, LO}. It supports half-selective load,
// accumulate-add (MADD), accumulate-subtract (MSUB) and clear. Accumulate ops
// are captured at acceptance and commit LAT edges later. Busy is high for the
// whole of that window, so the pipeline controller can stall mfhi/mflo and any
// new HI/LO op until the result has landed.
//
// Parameters
//   DATA_W : width of HI and of LO (accumulator is 2*DATA_W)
//   LAT    : edges from acceptance to commit, legal range 1..4
//
// Compile-time option
//   SATURATE_EN : when defined, MADD/MSUB are signed and saturating, and
//                 Overflow is a sticky flag. When undefined, MADD/MSUB wrap
//                 modulo 2^(2*DATA_W) and Overflow is tied to 0.
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst        in   asynchronous reset, active-high
//   InValid    in   op request strobe, accepted when Busy=0
//   Op         in   0 NOP, 1 LOAD, 2 MADD, 3 MSUB, 4 CLEAR, 5-7 NOP
//   WriteEnH   in   LOAD: write HI
//   WriteEnL   in   LOAD: write LO
//   WriteData  in   LOAD source / MADD-MSUB operand (2*DATA_W)
//   Busy       out  accumulate in flight, requests are dropped while high
//   ReadDataH  out  committed HI
//   ReadDataL  out  committed LO
//   Overflow   out  sticky saturation flag
//   debugHi    out  mirror of HI
//   debugLo    out  mirror of LO
//
// State table (single pipeline slot)
//   state   | meaning
//   S_IDLE  | no accumulate in flight, requests are accepted
//   S_PEND  | accumulate captured, cnt_q counts down to the commit edge
// ============================================================================
module hilo_acc_unit #(
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  InValid,
    input  logic [2:0]            Op,
    input  logic                  WriteEnH,
    input  logic                  WriteEnL,
    input  logic [2*DATA_W-1:0]   WriteData,
    output logic                  Busy,
    output logic [DATA_W-1:0]     ReadDataH,
    output logic [DATA_W-1:0]     ReadDataL,
    output logic                  Overflow,
    output logic [DATA_W-1:0]     debugHi,
    output logic [DATA_W-1:0]     debugLo
);

    localparam int ACC_W = 2 * DATA_W;
    // LAT is at most 4, so the countdown never exceeds 3.
    localparam int CNT_W = 2;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MSUB  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    opnd_q;
    logic                sub_q;
    logic                busy_q;
    logic [ACC_W-1:0]    acc_commit_d;

`ifdef SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0]      res_ext;
    logic                sat_ovf_d;
    logic                ovf_q;

    // One guard bit of sign extension: the signed result is out of range
    // exactly when the guard bit and the accumulator MSB disagree, and the
    // guard bit then gives the true sign for choosing the clamp value.
    always_comb begin
        res_ext      = '0;
        sat_ovf_d    = 1'b0;
        acc_commit_d = '0;
        if (sub_q) begin
            res_ext = {acc_q[ACC_W-1], acc_q} - {opnd_q[ACC_W-1], opnd_q};
        end else begin
            res_ext = {acc_q[ACC_W-1], acc_q} + {opnd_q[ACC_W-1], opnd_q};
        end
        sat_ovf_d    = res_ext[ACC_W] ^ res_ext[ACC_W-1];
        acc_commit_d = res_ext[ACC_W-1:0];
        if (sat_ovf_d) begin
            acc_commit_d = res_ext[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

    assign Overflow = ovf_q;
`else
    always_comb begin
        acc_commit_d = '0;
        if (sub_q) begin
            acc_commit_d = acc_q - opnd_q;
        end else begin
            acc_commit_d = acc_q + opnd_q;
        end
    end

    assign Overflow = 1'b0;
`endif

    // Acceptance only happens in S_IDLE, which is exactly Busy=0; the commit
    // edge leaves S_PEND, so a commit and an acceptance can never share an edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SATURATE_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (InValid) begin
                        case (Op)
                            OP_LOAD: begin
                                if (WriteEnH) begin
                                    acc_q[ACC_W-1:DATA_W] <= WriteData[ACC_W-1:DATA_W];
                                end
                                if (WriteEnL) begin
                                    acc_q[DATA_W-1:0] <= WriteData[DATA_W-1:0];
                                end
                            end
                            OP_CLEAR: begin
                                acc_q <= '0;
`ifdef SATURATE_EN
                                ovf_q <= 1'b0;
`endif
                            end
                            OP_MADD, OP_MSUB: begin
                                opnd_q  <= WriteData;
                                sub_q   <= (Op == OP_MSUB);
                                cnt_q   <= CNT_W'(LAT - 1);
                                busy_q  <= 1'b1;
                                state_q <= S_PEND;
                            end
                            default: begin
                                // NOP and 5-7: accepted, no effect
                            end
                        endcase
                    end
                end
                S_PEND: begin
                    if (cnt_q == '0) begin
                        acc_q   <= acc_commit_d;
`ifdef SATURATE_EN
                        ovf_q   <= ovf_q | sat_ovf_d;
`endif
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign ReadDataH = acc_q[ACC_W-1:DATA_W];
    assign ReadDataL = acc_q[DATA_W-1:0];
    assign debugHi   = acc_q[ACC_W-1:DATA_W];
    assign debugLo   = acc_q[DATA_W-1:0];

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Bench for hilo_acc_unit. The driver issues ops and, using a plain model of
// the accumulator, pushes the expected visible state for specific cycles into
// a scoreboard queue. A separate monitor samples the DUT on each falling edge
// and compares against whatever entries are due for that cycle.
module tb_hilo_acc_unit;

    localparam int W   = 32;
    localparam int LAT = 2;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] MADD = 3'd2;
    localparam logic [2:0] MSUB = 3'd3;
    localparam logic [2:0] CLR  = 3'd4;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            InValid;
    logic [2:0]      Op;
    logic            WriteEnH;
    logic            WriteEnL;
    logic [2*W-1:0]  WriteData;
    logic            Busy;
    logic [W-1:0]    ReadDataH;
    logic [W-1:0]    ReadDataL;
    logic            Overflow;
    logic [W-1:0]    debugHi;
    logic [W-1:0]    debugLo;

    hilo_acc_unit #(.DATA_W(W), .LAT(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .Op(Op),
        .WriteEnH(WriteEnH), .WriteEnL(WriteEnL), .WriteData(WriteData),
        .Busy(Busy), .ReadDataH(ReadDataH), .ReadDataL(ReadDataL),
        .Overflow(Overflow), .debugHi(debugHi), .debugLo(debugLo)
    );

    typedef struct {
        int          cyc;
        logic [63:0] acc;
        logic        busy;
        logic        ovf;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    string       cur_tag = "init";

    logic [63:0] m_acc = '0;
    logic        m_ovf = 1'b0;
    int          free_edge = 0;

    initial forever #5 Clk = ~Clk;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input string field,
                         input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s %s cyc=%0d: got %h, want %h", tag, field, cyc, got, want);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL %s missed: entry for cyc=%0d not checked (now %0d)", e.tag, e.cyc, cyc);
            end
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check(e.tag, "HI",      {32'h0, ReadDataH}, {32'h0, e.acc[63:32]});
                check(e.tag, "LO",      {32'h0, ReadDataL}, {32'h0, e.acc[31:0]});
                check(e.tag, "dbgHI",   {32'h0, debugHi},   {32'h0, e.acc[63:32]});
                check(e.tag, "dbgLO",   {32'h0, debugLo},   {32'h0, e.acc[31:0]});
                check(e.tag, "Busy",    {63'h0, Busy},      {63'h0, e.busy});
                check(e.tag, "Overflow",{63'h0, Overflow},  {63'h0, e.ovf});
            end
        end
    end

    function automatic void push(input int c, input logic [63:0] a,
                                 input logic b, input logic o);
        exp_t e;
        e.cyc  = c;
        e.acc  = a;
        e.busy = b;
        e.ovf  = o;
        e.tag  = cur_tag;
        sb.push_back(e);
    endfunction

    // Reference arithmetic: plain wide integer math on the 64-bit accumulator.
    function automatic void model_acc(input logic sub, input logic [63:0] d,
                                      output logic [63:0] r, output logic o);
`ifdef SATURATE_EN
        logic signed [64:0] s;
        logic signed [64:0] maxv;
        logic signed [64:0] minv;
        maxv = 65'h0_7FFF_FFFF_FFFF_FFFF;
        minv = 65'h1_8000_0000_0000_0000;
        if (sub) s = $signed({m_acc[63], m_acc}) - $signed({d[63], d});
        else     s = $signed({m_acc[63], m_acc}) + $signed({d[63], d});
        o = 1'b0;
        r = s[63:0];
        if (s > maxv) begin
            r = 64'h7FFF_FFFF_FFFF_FFFF;
            o = 1'b1;
        end else if (s < minv) begin
            r = 64'h8000_0000_0000_0000;
            o = 1'b1;
        end
`else
        r = sub ? (m_acc - d) : (m_acc + d);
        o = 1'b0;
`endif
    endfunction

    // Called just after a falling edge. Holds InValid until the model says the
    // request is taken, then releases it.
    task automatic issue(input logic [2:0] op, input logic eh, input logic el,
                         input logic [63:0] d);
        int          k;
        int          guard;
        logic [63:0] old;
        logic        oo;
        logic [63:0] r;
        logic        o;
        k = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
        case (op)
            LOAD: begin
                if (eh) m_acc[63:32] = d[63:32];
                if (el) m_acc[31:0]  = d[31:0];
                push(k, m_acc, 1'b0, m_ovf);
            end
            CLR: begin
                m_acc = '0;
                m_ovf = 1'b0;
                push(k, m_acc, 1'b0, m_ovf);
            end
            MADD, MSUB: begin
                old = m_acc;
                oo  = m_ovf;
                model_acc(op == MSUB, d, r, o);
                for (int i = 0; i < LAT; i++) push(k + i, old, 1'b1, oo);
                m_acc = r;
                m_ovf = oo | o;
                push(k + LAT, m_acc, 1'b0, m_ovf);
                free_edge = k + LAT + 1;
            end
            default: push(k, m_acc, 1'b0, m_ovf);
        endcase
        InValid   = 1'b1;
        Op        = op;
        WriteEnH  = eh;
        WriteEnL  = el;
        WriteData = d;
        guard = 0;
        while (cyc < k && guard < 50) begin
            @(negedge Clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            tests++;
            fails++;
            $display("FAIL %s issue-timeout: cyc=%0d, want %0d", cur_tag, cyc, k);
        end
        InValid   = 1'b0;
        Op        = NOP;
        WriteEnH  = 1'b0;
        WriteEnL  = 1'b0;
        WriteData = {$urandom, $urandom};
    endtask

    // Idle cycles; the resting state is checked once no accumulate is pending.
    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            if (cyc + 1 >= free_edge - 1) push(cyc + 1, m_acc, 1'b0, m_ovf);
            @(negedge Clk);
            #1;
        end
    endtask

    function automatic logic [63:0] rnd_data();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = 64'($urandom_range(0, 15));
            2: v = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
            default: v = {($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        logic [2:0] op;
        Rst       = 1'b1;
        InValid   = 1'b0;
        Op        = NOP;
        WriteEnH  = 1'b0;
        WriteEnL  = 1'b0;
        WriteData = '0;
        @(negedge Clk);
        #1;

        cur_tag = "reset";
        idle_check(2);
        Rst = 1'b0;
        idle_check(1);

        cur_tag = "sel_load";
        issue(LOAD, 1'b1, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
        idle_check(2);

        cur_tag = "load_both_off";
        issue(LOAD, 1'b0, 1'b0, 64'h1111_2222_3333_4444);
        idle_check(1);

        cur_tag = "carry";
        issue(LOAD, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF);
        issue(MADD, 1'b0, 1'b0, 64'h1);
        idle_check(3);

`ifndef SATURATE_EN
        cur_tag = "msub_wrap";
        issue(CLR, 1'b0, 1'b0, 64'h0);
        issue(MSUB, 1'b0, 1'b0, 64'h1);
        idle_check(3);
`endif

        cur_tag = "busy_drop";
        issue(CLR, 1'b0, 1'b0, 64'h0);
        issue(MADD, 1'b0, 1'b0, 64'h3);
        issue(LOAD, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0);
        idle_check(2);

        cur_tag = "b2b";
        issue(CLR, 1'b0, 1'b0, 64'h0);
        issue(MADD, 1'b0, 1'b0, 64'h2);
        issue(MADD, 1'b0, 1'b0, 64'h2);
        idle_check(3);

        cur_tag = "rst_mid";
        issue(LOAD, 1'b1, 1'b1, 64'h1);
        issue(MADD, 1'b0, 1'b0, 64'h5);
        while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
        Rst       = 1'b1;
        m_acc     = '0;
        m_ovf     = 1'b0;
        free_edge = 0;
        idle_check(2);
        Rst = 1'b0;
        idle_check(4);

`ifdef SATURATE_EN
        cur_tag = "sat_pos";
        issue(LOAD, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF);
        issue(MADD, 1'b0, 1'b0, 64'h1);
        idle_check(1);
        cur_tag = "sat_load_keeps_ovf";
        issue(LOAD, 1'b1, 1'b1, 64'h5);
        idle_check(1);
        cur_tag = "sat_clear";
        issue(CLR, 1'b0, 1'b0, 64'h0);
        idle_check(1);
        cur_tag = "sat_neg";
        issue(LOAD, 1'b1, 1'b1, 64'h8000_0000_0000_0000);
        issue(MSUB, 1'b0, 1'b0, 64'h1);
        idle_check(2);
`endif

        cur_tag = "random";
        for (int n = 0; n < 250; n++) begin
            op = 3'($urandom_range(0, 7));
            issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_data());
            idle_check($urandom_range(0, 2));
        end

        cur_tag = "drain";
        idle_check(LAT + 2);
        for (int g = 0; g < 100 && sb.size() > 0; g++) @(negedge Clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_acc_unit.md
Name: hilo_acc_unit

Overview:
Parametrised HI/LO register pair with a multi-cycle multiply-accumulate datapath for the processor's mult/div/madd path.
- Holds a 2*DATA_W accumulator, split into HI (upper half) and LO (lower half).
- Supports half-selective load, accumulate-add, accumulate-subtract and clear.
- Accumulate ops run through an LAT-stage pipeline; a Busy handshake lets the pipeline controller stall mfhi/mflo and new HI/LO ops until the result commits.

Parameters:
DATA_W, 32, width of HI and of LO; the accumulator is 2*DATA_W bits.
LAT, 2, accumulate latency in cycles from acceptance to commit; legal range 1..4.

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  asynchronous reset, active-high
InValid  input  1  op request strobe
Op  input  3  0 NOP, 1 LOAD, 2 MADD, 3 MSUB, 4 CLEAR, 5-7 treated as NOP
WriteEnH  input  1  LOAD only: write HI
WriteEnL  input  1  LOAD only: write LO
WriteData  input  2*DATA_W  LOAD source; MADD/MSUB operand
Busy  output  1  accumulate in flight; requests are ignored while high
ReadDataH  output  DATA_W  current committed HI
ReadDataL  output  DATA_W  current committed LO
Overflow  output  1  sticky saturation flag (see Optional Feature)
debugHi  output  DATA_W  mirror of HI for ILA
debugLo  output  DATA_W  mirror of LO for ILA

Behaviour:
- Reset (async, Rst=1):
  - HI=0, LO=0, Busy=0, Overflow=0, pipeline valid bits cleared.
  - Any in-flight MADD/MSUB is discarded and never commits.
- Acceptance: a request is accepted at a rising edge when InValid=1, Busy=0 and Rst=0. InValid with Op=NOP/5-7 is accepted with no effect.
- LOAD:
  - At the accepting edge, HI<=WriteData[2W-1:W] if WriteEnH; LO<=WriteData[W-1:0] if WriteEnL.
  - Both enables 0 is a no-op. Busy stays 0.
- CLEAR: HI<=0, LO<=0, Overflow<=0 at the accepting edge. Busy stays 0.
- MADD/MSUB:
  - Operand and op are captured at the accepting edge k.
  - Busy=1 from edge k until edge k+LAT.
  - At edge k+LAT, {HI,LO} <= {HI,LO} + operand (MADD) or {HI,LO} - operand (MSUB), using the {HI,LO} value present at commit.
  - Busy falls after edge k+LAT, so a new request can be accepted at edge k+LAT+1.
  - Back-to-back issue therefore gives one accumulate per LAT+1 cycles.
- Arithmetic: modulo 2^(2W) wrap, two's complement, with no carry-out port.
- Busy: registered, glitch-free; there is no combinational path from InValid to Busy.
- Requests while Busy=1 are dropped; the requester must hold InValid until Busy=0.
- Read path: ReadDataH/L and debugHi/Lo are driven directly from the HI/LO registers. They show the new value in the cycle after the writing edge, and show the pre-accumulate value while Busy=1.
- Simultaneous events: only one op is accepted per edge. A commit and an acceptance never coincide, because Busy blocks acceptance through the commit edge.
- Rst deasserted mid-cycle: state is held at reset values until the next rising edge.
- State machine, per pipeline slot:
  - IDLE -> (accept MADD/MSUB) -> PEND with countdown LAT-1.
  - PEND decrements each cycle; PEND at 0 -> COMMIT edge -> IDLE.
  - For LAT=1, accept goes straight to commit at the next edge.

Optional Feature:
SATURATE_EN:
- Defined:
  - MADD/MSUB treat {HI,LO} and the operand as signed 2W-bit values.
  - A result outside the signed range clamps to the most positive value 0x7F..F or the most negative value 0x80..0, and Overflow is set.
  - Overflow is sticky until CLEAR or Rst.
  - LOAD does not affect Overflow.
- Undefined: modulo wrap, and Overflow is tied to 0.

Test Plan:
- Reset mid-MADD: LOAD {HI,LO}=0x1, issue MADD operand 0x5, assert Rst one cycle after accept -> HI=LO=0, Busy=0, and no commit ever appears.
- Selective LOAD: WriteData=0xAAAA_BBBB_CCCC_DDDD, WriteEnH=1, WriteEnL=0, on prior {0,0} -> ReadDataH=0xAAAABBBB, ReadDataL=0, Busy never rises.
- MADD carry across halves (LAT=2): {HI,LO}={0,0xFFFF_FFFF}, MADD 0x1 -> Busy high exactly 2 cycles, then HI=0x1, LO=0x0.
- MSUB wrap, macro off: {0,0}, MSUB 0x1 -> HI=LO=0xFFFF_FFFF, Overflow=0.
- Busy drop and back-to-back: MADD 0x3 accepted, a LOAD held on InValid during Busy -> LOAD is ignored while Busy=1 and accepted at edge k+3. Two MADDs of 0x2 from 0 give 0x4 after 6 cycles.
- SATURATE_EN: {HI,LO}=0x7FFF_FFFF_FFFF_FFFF, MADD 0x1 -> result stays 0x7FFF…F, Overflow=1. A following CLEAR -> all 0, Overflow=0.
